// File: rtl/max_pool.sv
// 2x2 stride-2 max-pooling stage: reads conv ofmaps from DRAM one window at a time
// and writes one pooled pixel per window, under an enable/done handshake.
module max_pool #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 18,
   parameter int                    IFMAP_WIDTH  = 28,
   parameter int                    IFMAP_HEIGHT = 28,
   parameter int                    NUM_CHNL     = 6,
   parameter logic [ADDR_WIDTH-1:0] IN_BASE      = '0,
   parameter logic [ADDR_WIDTH-1:0] OUT_BASE     = ADDR_WIDTH'('h8000)
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  enable,
   input  logic                  dram_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  dram_en_rd,
   output logic                  dram_en_wr,
   output logic                  done
);

   localparam int OW   = IFMAP_WIDTH / 2;
   localparam int OH   = IFMAP_HEIGHT / 2;
   localparam int C_W  = $clog2(OW + 1);
   localparam int R_W  = $clog2(OH + 1);
   localparam int CH_W = $clog2(NUM_CHNL + 1);

   localparam logic [C_W-1:0]        C_LAST    = C_W'(OW - 1);
   localparam logic [R_W-1:0]        R_LAST    = R_W'(OH - 1);
   localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(NUM_CHNL - 1);
   localparam logic [ADDR_WIDTH-1:0] IN_W      = ADDR_WIDTH'(IFMAP_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] IN_STRIDE = ADDR_WIDTH'(IFMAP_WIDTH * IFMAP_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] OUT_W     = ADDR_WIDTH'(OW);
   localparam logic [ADDR_WIDTH-1:0] OUT_STRIDE = ADDR_WIDTH'(OW * OH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [R_W-1:0]          r_q, r_d;
   logic [C_W-1:0]          c_q, c_d;
   logic [1:0]              win_q, win_d;
   logic signed [DATA_WIDTH-1:0] max_q, max_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic [ADDR_WIDTH-1:0]   addr_in_q, addr_in_d;
   logic [ADDR_WIDTH-1:0]   addr_out_q, addr_out_d;
   logic                    rd_en_q, rd_en_d;
   logic                    wr_en_q, wr_en_d;
   logic                    done_q, done_d;
   logic                    last_pix;

   // {r, dy} is 2r+dy and {c, dx} is 2c+dx; everything wraps at ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [CH_W-1:0] ch,
                                                     input logic [R_W-1:0]  r,
                                                     input logic [C_W-1:0]  c,
                                                     input logic [1:0]      win);
      logic [ADDR_WIDTH-1:0] row;
      logic [ADDR_WIDTH-1:0] col;
      row = ADDR_WIDTH'({r, win[1]});
      col = ADDR_WIDTH'({c, win[0]});
      return IN_BASE + ADDR_WIDTH'(ch) * IN_STRIDE + row * IN_W + col;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [CH_W-1:0] ch,
                                                     input logic [R_W-1:0]  r,
                                                     input logic [C_W-1:0]  c);
      return OUT_BASE + ADDR_WIDTH'(ch) * OUT_STRIDE + ADDR_WIDTH'(r) * OUT_W + ADDR_WIDTH'(c);
   endfunction

   assign last_pix = (c_q == C_LAST) && (r_q == R_LAST) && (ch_q == CH_LAST);

   always_comb begin
      // NOTE: every *_d defaults to its *_q first so no path leaves a latch.
      state_d    = state_q;
      ch_d       = ch_q;
      r_d        = r_q;
      c_d        = c_q;
      win_d      = win_q;
      max_d      = max_q;
      data_out_d = data_out_q;
      addr_in_d  = addr_in_q;
      addr_out_d = addr_out_q;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_RD;
               ch_d    = '0;
               r_d     = '0;
               c_d     = '0;
               win_d   = '0;
            end
         end
         S_RD: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (dram_valid) begin
               if ((win_q == 2'd0) || ($signed(data_in) > max_q)) max_d = data_in;
               if (win_q == 2'd3) state_d = S_WR;
               else               win_d   = win_q + 2'd1;
            end
         end
         S_WR: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else begin
               win_d   = '0;
               state_d = last_pix ? S_DONE : S_RD;
               if (c_q != C_LAST) begin
                  c_d = c_q + C_W'(1);
               end else begin
                  c_d = '0;
                  if (r_q != R_LAST) begin
                     r_d = r_q + R_W'(1);
                  end else begin
                     r_d  = '0;
                     ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                  end
               end
            end
         end
         S_DONE: begin
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      rd_en_d = (state_d == S_RD);
      wr_en_d = (state_d == S_WR);
      done_d  = (state_d == S_DONE);
      if (state_d == S_RD) addr_in_d = rd_addr(ch_d, r_d, c_d, win_d);
      if (state_d == S_WR) begin
         data_out_d = max_d;
         addr_out_d = wr_addr(ch_d, r_d, c_d);
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         r_q        <= '0;
         c_q        <= '0;
         win_q      <= '0;
         max_q      <= '0;
         data_out_q <= '0;
         addr_in_q  <= '0;
         addr_out_q <= '0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         r_q        <= r_d;
         c_q        <= c_d;
         win_q      <= win_d;
         max_q      <= max_d;
         data_out_q <= data_out_d;
         addr_in_q  <= addr_in_d;
         addr_out_q <= addr_out_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         done_q     <= done_d;
      end
   end

   assign data_out   = data_out_q;
   assign addr_in    = addr_in_q;
   assign addr_out   = addr_out_q;
   assign dram_en_rd = rd_en_q;
   assign dram_en_wr = wr_en_q;
   assign done       = done_q;

endmodule

// File: tb/tb_max_pool.sv
// Self-checking bench for max_pool: a DRAM responder with programmable read latency
// plus a scoreboard fed by a loop-based reference model of 2x2 max pooling.
module tb_max_pool;

   localparam int              DW       = 32;
   localparam int              AW       = 18;
   localparam logic [AW-1:0]   OUT_BASE = 18'h8000;
   localparam int              TIMEOUT  = 5000;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          srstn;
   logic          enable     [2];
   logic          dram_valid [2];
   logic [DW-1:0] data_in    [2];
   logic [DW-1:0] data_out   [2];
   logic [AW-1:0] addr_in    [2];
   logic [AW-1:0] addr_out   [2];
   logic          en_rd      [2];
   logic          en_wr      [2];
   logic          done       [2];

   int geo_w  [2] = '{4, 5};
   int geo_h  [2] = '{4, 5};
   int geo_nc [2] = '{1, 2};

   logic [DW-1:0] mem [0:255];
   logic [AW-1:0] exp_rd [$];
   wr_t           exp_wr [$];
   wr_t           e_wr;

   int            checks = 0;
   int            errors = 0;
   int            cur = 0;
   int            delay_mode = 0;
   bit            noise = 1'b0;
   int            wait_cnt = 0;
   int            rd_seen = 0;
   int            wr_seen = 0;
   logic [DW-1:0] first_wr;
   logic [AW-1:0] first_rd;

   always #5 clk = ~clk;

   max_pool #(.IFMAP_WIDTH(4), .IFMAP_HEIGHT(4), .NUM_CHNL(1)) u_a (
      .clk(clk), .srstn(srstn), .enable(enable[0]), .dram_valid(dram_valid[0]),
      .data_in(data_in[0]), .data_out(data_out[0]), .addr_in(addr_in[0]),
      .addr_out(addr_out[0]), .dram_en_rd(en_rd[0]), .dram_en_wr(en_wr[0]), .done(done[0])
   );

   max_pool #(.IFMAP_WIDTH(5), .IFMAP_HEIGHT(5), .NUM_CHNL(2)) u_b (
      .clk(clk), .srstn(srstn), .enable(enable[1]), .dram_valid(dram_valid[1]),
      .data_in(data_in[1]), .data_out(data_out[1]), .addr_in(addr_in[1]),
      .addr_out(addr_out[1]), .dram_en_rd(en_rd[1]), .dram_en_wr(en_wr[1]), .done(done[1])
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int next_delay();
      return (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
   endfunction

   // DRAM responder and scoreboard, acting on the falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         dram_valid[k] = 1'b0;
         data_in[k]    = noise ? $urandom : '0;
      end
      if (noise && !en_rd[cur]) dram_valid[cur] = 1'($urandom_range(0, 1));
      if (srstn) begin
         if (en_rd[cur] || en_wr[cur]) check("rd_wr_excl", DW'(en_rd[cur] & en_wr[cur]), '0);
         if (en_rd[cur]) begin
            if (exp_rd.size() > 0) check("rd_addr", DW'(addr_in[cur]), DW'(exp_rd[0]));
            if (wait_cnt == 0) begin
               dram_valid[cur] = 1'b1;
               data_in[cur]    = mem[addr_in[cur][7:0]];
               if (rd_seen == 0) first_rd = addr_in[cur];
               rd_seen++;
               if (exp_rd.size() > 0) void'(exp_rd.pop_front());
               wait_cnt = next_delay();
            end else begin
               wait_cnt--;
            end
         end
         if (en_wr[cur]) begin
            if (exp_wr.size() > 0) begin
               e_wr = exp_wr.pop_front();
               check("wr_addr", DW'(addr_out[cur]), DW'(e_wr.addr));
               check("wr_data", data_out[cur], e_wr.data);
            end
            if (wr_seen == 0) first_wr = data_out[cur];
            wr_seen++;
         end
      end
   end

   // Reference: every output pixel is the signed max of its 2x2 window.
   task automatic build_model(input int k);
      int w, h, nc, ow, oh, a;
      logic signed [DW-1:0] m;
      wr_t e;
      w  = geo_w[k];
      h  = geo_h[k];
      nc = geo_nc[k];
      ow = w / 2;
      oh = h / 2;
      exp_rd.delete();
      exp_wr.delete();
      m = '0;
      for (int ch = 0; ch < nc; ch++)
         for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
               for (int win = 0; win < 4; win++) begin
                  a = ch * w * h + (2 * r + win / 2) * w + 2 * c + win % 2;
                  exp_rd.push_back(AW'(a));
                  if (win == 0 || $signed(mem[a]) > m) m = mem[a];
               end
               e.addr = AW'(int'(OUT_BASE) + ch * ow * oh + r * ow + c);
               e.data = m;
               exp_wr.push_back(e);
            end
   endtask

   task automatic fill(input bit rnd);
      for (int i = 0; i < 256; i++)
         mem[i] = !rnd ? DW'(i) :
                  ($urandom_range(0, 1) != 0) ? $urandom : DW'($urandom_range(0, 8)) - 32'd4;
   endtask

   task automatic start(input int k, input int dmode, input bit nz);
      cur        = k;
      delay_mode = dmode;
      noise      = nz;
      wait_cnt   = next_delay();
      rd_seen    = 0;
      wr_seen    = 0;
      build_model(k);
      @(negedge clk);
      enable[k] = 1'b1;
   endtask

   // Waits for done, checks totals and the done/enable handshake.
   task automatic finish_run(input int k, input int exp_cycles);
      int cyc, npix;
      npix = (geo_w[k] / 2) * (geo_h[k] / 2) * geo_nc[k];
      cyc  = 0;
      while (cyc < TIMEOUT && !done[k]) begin
         @(negedge clk);
         cyc++;
      end
      check("done_reached", DW'(done[k]), 1);
      if (exp_cycles >= 0) check("run_cycles", DW'(cyc), DW'(exp_cycles));
      check("rd_count", DW'(rd_seen), DW'(4 * npix));
      check("wr_count", DW'(wr_seen), DW'(npix));
      repeat (3) begin
         @(negedge clk);
         check("done_hold", DW'(done[k]), 1);
         check("done_strobes", DW'({en_rd[k], en_wr[k]}), 0);
      end
      enable[k] = 1'b0;
      @(negedge clk);
      check("done_clear", DW'(done[k]), 0);
   endtask

   task automatic wait_reads(input int n);
      int cyc;
      cyc = 0;
      while (cyc < TIMEOUT && rd_seen < n) begin
         @(negedge clk);
         cyc++;
      end
      check("reads_reached", DW'(rd_seen >= n), 1);
   endtask

   initial begin
      int wr_before;
      srstn = 1'b0;
      for (int k = 0; k < 2; k++) enable[k] = 1'b0;
      fill(1'b0);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_data_out", data_out[k], '0);
         check("rst_addr_in", DW'(addr_in[k]), '0);
         check("rst_addr_out", DW'(addr_out[k]), '0);
         check("rst_en_rd", DW'(en_rd[k]), '0);
         check("rst_en_wr", DW'(en_wr[k]), '0);
         check("rst_done", DW'(done[k]), '0);
      end
      srstn = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp 0..15, zero-latency reads: writes 5,7,13,15, done 20 cycles after first read.
      fill(1'b0);
      start(0, 0, 1'b0);
      finish_run(0, 1 + 4 * 5);
      check("ramp_first", first_wr, 32'd5);

      // Signed window {-3,-1,-7,-2} must pool to -1.
      fill(1'b0);
      mem[0] = -32'sd3;
      mem[1] = -32'sd1;
      mem[4] = -32'sd7;
      mem[5] = -32'sd2;
      start(0, 0, 1'b1);
      finish_run(0, 1 + 4 * 5);
      check("signed_max", first_wr, 32'hFFFF_FFFF);

      // Three-cycle read latency: address held, same results, 17 cycles per pixel.
      fill(1'b0);
      start(0, 3, 1'b0);
      finish_run(0, 1 + 4 * 17);

      // 5x5 with two channels: odd row/column skipped, channel 1 reads from +25.
      fill(1'b0);
      start(1, 0, 1'b0);
      finish_run(1, 1 + 8 * 5);

      // Random data, random latency, bus noise outside reads.
      for (int i = 0; i < 6; i++) begin
         fill(1'b1);
         start(i % 2, -1, 1'b1);
         finish_run(i % 2, -1);
      end

      // Reset asserted mid-read: outputs clear at once, next run restarts at IN_BASE.
      fill(1'b1);
      start(0, -1, 1'b1);
      wait_reads(6);
      check("pre_rst_rd", DW'(en_rd[0]), 1);
      #2 srstn = 1'b0;
      #1;
      check("mid_rst_data_out", data_out[0], '0);
      check("mid_rst_addr_in", DW'(addr_in[0]), '0);
      check("mid_rst_addr_out", DW'(addr_out[0]), '0);
      check("mid_rst_strobes", DW'({en_rd[0], en_wr[0], done[0]}), '0);
      enable[0] = 1'b0;
      @(negedge clk);
      srstn = 1'b1;
      start(0, 0, 1'b0);
      finish_run(0, 1 + 4 * 5);
      check("restart_first_rd", DW'(first_rd), '0);

      // Enable dropped during a read: back to idle, no write strobe afterwards.
      fill(1'b1);
      start(1, -1, 1'b0);
      wait_reads(5);
      while (!en_rd[1]) @(negedge clk);
      enable[1] = 1'b0;
      wr_before = wr_seen;
      @(negedge clk);
      check("abort_en_rd", DW'(en_rd[1]), 0);
      check("abort_en_wr", DW'(en_wr[1]), 0);
      repeat (5) @(negedge clk);
      check("abort_no_wr", DW'(wr_seen), DW'(wr_before));
      check("abort_done", DW'(done[1]), 0);
      start(1, -1, 1'b1);
      finish_run(1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
